// File: rtl/riscv_pkg.sv
// Shared RV32I definitions used by the fetch unit and the main decode controller.
//   - opcode constants for the instruction classes the controller decodes
//   - PCSrc encodings driven by the controller into the fetch unit
//   - canonical NOP word (addi x0, x0, 0) loaded on reset
//   - fetch FSM state encoding
package riscv_pkg;

    localparam logic [6:0] R_TYPE    = 7'b0110011;
    localparam logic [6:0] LOAD      = 7'b0000011;
    localparam logic [6:0] IMMEDIATE = 7'b0010011;
    localparam logic [6:0] JALR      = 7'b1100111;
    localparam logic [6:0] STORE     = 7'b0100011;
    localparam logic [6:0] JAL       = 7'b1101111;
    localparam logic [6:0] BRANCH    = 7'b1100011;
    localparam logic [6:0] LUI       = 7'b0110111;

    typedef enum logic [1:0] {
        PCSRC_PLUS4  = 2'b00,
        PCSRC_TARGET = 2'b01,
        PCSRC_JALR   = 2'b10,
        PCSRC_RSVD   = 2'b11
    } pcsrc_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_ISSUE = 3'd3,
        ST_HALT  = 3'd4
    } fetch_state_e;

endpackage

// File: rtl/pc_next_logic.sv
// Next-PC selection for the fetch unit (purely combinational).
//   pc, pc_src, imm_ext, alu_result -> next_pc, misaligned
// The reserved PCSrc code falls back to sequential flow. The JALR target has
// bit 0 cleared; bit 1 is left as-is so a bad JALR target is flagged.
module pc_next_logic
    import riscv_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [1:0]  pc_src,
    input  logic [31:0] imm_ext,
    input  logic [31:0] alu_result,
    output logic [31:0] next_pc,
    output logic        misaligned
);

    always_comb begin
        next_pc = pc + 32'd4;
        case (pcsrc_e'(pc_src))
            PCSRC_TARGET: next_pc = pc + imm_ext;
            PCSRC_JALR:   next_pc = {alu_result[31:1], 1'b0};
            default:      next_pc = pc + 32'd4;
        endcase
    end

    assign misaligned = |next_pc[1:0];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage ahead of the RV32I decode controller.
// Holds the PC, fetches one word at a time over a req/ready memory port,
// presents the latched instruction for one or more ISSUE cycles and then
// steps the PC using the controller's PCSrc.
//   clk, rst_n                 core clock, async active-low reset
//   imem_req/addr/ready/rdata  variable-latency instruction memory port
//   stall                      holds ISSUE (PC and instruction frozen)
//   PCSrc, ImmExt, ALUResult   next-PC select and operands from controller
//   instr_valid, instr, opcode, func3, func7, pc, pc_plus4  to controller
//   fault                      sticky: misaligned target or fetch timeout
module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic [1:0]  PCSrc,
    input  logic [31:0] ImmExt,
    input  logic [31:0] ALUResult,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [6:0]  opcode,
    output logic [2:0]  func3,
    output logic [6:0]  func7,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fault
);

    localparam int CW = $clog2(TIMEOUT + 1);

    fetch_state_e   state_q, state_d;
    logic [31:0]    pc_q, pc_d;
    logic [31:0]    instr_q, instr_d;
    logic           fault_q, fault_d;
    logic [CW-1:0]  wait_cnt_q, wait_cnt_d;
    logic [CW-1:0]  wait_cnt_inc;
    logic [31:0]    next_pc;
    logic           misaligned;

    pc_next_logic u_pc_next (
        .pc         (pc_q),
        .pc_src     (PCSrc),
        .imm_ext    (ImmExt),
        .alu_result (ALUResult),
        .next_pc    (next_pc),
        .misaligned (misaligned)
    );

    // wait_cnt counts request cycles that went unanswered, FETCH included.
    assign wait_cnt_inc = wait_cnt_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        fault_d    = fault_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            ST_IDLE: state_d = ST_FETCH;
            ST_FETCH: begin
                if (imem_ready) begin
                    instr_d = imem_rdata;
                    state_d = ST_ISSUE;
                end else begin
                    wait_cnt_d = CW'(1);
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_ready) begin
                    instr_d = imem_rdata;
                    state_d = ST_ISSUE;
                end else begin
                    wait_cnt_d = wait_cnt_inc;
                    if (wait_cnt_inc >= CW'(TIMEOUT)) begin
                        fault_d = 1'b1;
                        state_d = ST_HALT;
                    end
                end
            end
            ST_ISSUE: begin
                if (!stall) begin
                    if (misaligned) begin
                        fault_d = 1'b1;
                        state_d = ST_HALT;
                    end else begin
                        pc_d    = next_pc;
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= NOP_INSTR;
            fault_q    <= 1'b0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            fault_q    <= fault_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Request is a pure decode of the state register, so it drops the
    // instant reset is asserted and the address (pc_q) cannot move under it.
    assign imem_req    = (state_q == ST_FETCH) || (state_q == ST_WAIT);
    assign imem_addr   = pc_q;
    assign instr_valid = (state_q == ST_ISSUE);
    assign instr       = instr_q;
    assign opcode      = instr_q[6:0];
    assign func3       = instr_q[14:12];
    assign func7       = instr_q[31:25];
    assign pc          = pc_q;
    assign pc_plus4    = pc_q + 32'd4;
    assign fault       = fault_q;

endmodule
